// File: rtl/pipe_scheduler.sv
// Two-requester issue scheduler: arbitrates onto a fixed-latency datapath and queues results
// in a credit-protected FIFO. Define SCHED_STRICT_PRIO_EN for fixed requester-0 priority.
module pipe_scheduler #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned LAT   = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [4*WIDTH-1:0] ops0,
  input  logic [4*WIDTH-1:0] ops1,
  output logic [4*WIDTH-1:0] pipe_ops,
  output logic               pipe_issue,
  input  logic [WIDTH-1:0]   pipe_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WIDTH-1:0]   res_data,
  output logic               res_tag
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  logic            gnt_id;
  logic            credit;
  logic            xfer;
  logic            push;
  logic            push_tag;
  logic            pop;
  logic [CntW-1:0] occ_q, occ_d;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef SCHED_STRICT_PRIO_EN
  always_comb begin
    gnt_id = ~req_valid[0];
  end
`else
  logic last_q, last_d;

  always_comb begin
    gnt_id = 1'b0;
    unique case (req_valid)
      2'b11:   gnt_id = ~last_q;
      2'b10:   gnt_id = 1'b1;
      default: gnt_id = 1'b0;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (xfer) begin
      last_d = gnt_id;
    end
  end

  // Reset to 1 so requester 0 wins the first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // rst_n gates the handshake so nothing is offered while reset is held.
  assign credit = (occ_q < DepthC);
  assign xfer   = rst_n & credit & (|req_valid);

  always_comb begin
    req_ready  = 2'b00;
    pipe_issue = xfer;
    pipe_ops   = '0;
    if (xfer) begin
      req_ready = gnt_id ? 2'b10 : 2'b01;
      pipe_ops  = gnt_id ? ops1 : ops0;
    end
  end

  // ---------------------------------------------------------------------------
  // In-flight tracking
  // ---------------------------------------------------------------------------
  logic [LAT-1:0] fl_vld_q, fl_vld_d;
  logic [LAT-1:0] fl_tag_q, fl_tag_d;

  always_comb begin
    fl_vld_d    = fl_vld_q;
    fl_tag_d    = fl_tag_q;
    fl_vld_d[0] = xfer;
    fl_tag_d[0] = gnt_id;
    for (int unsigned i = 1; i < LAT; i++) begin
      fl_vld_d[i] = fl_vld_q[i-1];
      fl_tag_d[i] = fl_tag_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fl_vld_q <= '0;
      fl_tag_q <= '0;
    end else begin
      fl_vld_q <= fl_vld_d;
      fl_tag_q <= fl_tag_d;
    end
  end

  // Tail entry lines up with the datapath output for that issue.
  assign push     = fl_vld_q[LAT-1];
  assign push_tag = fl_tag_q[LAT-1];

  // ---------------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]  mem_q [DEPTH];
  logic [WIDTH:0]  head;
  logic [PtrW-1:0] wr_q, wr_d;
  logic [PtrW-1:0] rd_q, rd_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  assign res_valid = (cnt_q != '0);
  assign pop       = res_valid & res_ready;
  assign head      = mem_q[rd_q];
  assign res_data  = res_valid ? head[WIDTH-1:0] : '0;
  assign res_tag   = res_valid & head[WIDTH];

  // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH for free.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      wr_d = wr_q + PtrW'(1);
    end
    if (pop) begin
      rd_d = rd_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= {push_tag, pipe_out};
    end
  end

  // ---------------------------------------------------------------------------
  // Occupancy (in flight + queued) drives credit
  // ---------------------------------------------------------------------------
  always_comb begin
    occ_d = occ_q;
    unique case ({xfer, pop})
      2'b10:   occ_d = occ_q + CntW'(1);
      2'b01:   occ_d = occ_q - CntW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && (cnt_q == DepthC) && !pop))
        else $error("pipe_scheduler: result fifo push while full");
      assert (occ_q <= DepthC)
        else $error("pipe_scheduler: occupancy above depth");
    end
  end

endmodule

// File: tb/tb_pipe_scheduler.sv
// Directed bench for pipe_scheduler: stimulus pushes expected results into a scoreboard queue,
// a negedge monitor pops and compares every result handshake.
module tb_pipe_scheduler;

  localparam int WIDTH = 6;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [4*WIDTH-1:0] ops0;
  logic [4*WIDTH-1:0] ops1;
  logic [4*WIDTH-1:0] pipe_ops;
  logic               pipe_issue;
  logic [WIDTH-1:0]   pipe_out;
  logic               res_valid;
  logic               res_ready;
  logic [WIDTH-1:0]   res_data;
  logic               res_tag;

  int checks   = 0;
  int failures = 0;
  int lat;

  logic [WIDTH:0]   sb [$];
  logic [WIDTH:0]   mon_exp;
  logic [WIDTH-1:0] dp1, dp2, dp3;

  pipe_scheduler #(
    .WIDTH (WIDTH),
    .LAT   (LAT),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .ops0       (ops0),
    .ops1       (ops1),
    .pipe_ops   (pipe_ops),
    .pipe_issue (pipe_issue),
    .pipe_out   (pipe_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_tag    (res_tag)
  );

  always #5 clk = ~clk;

  // Datapath model: A field delayed three cycles.
  always @(posedge clk) begin
    dp1 <= pipe_ops[4*WIDTH-1 -: WIDTH];
    dp2 <= dp1;
    dp3 <= dp2;
  end
  assign pipe_out = dp3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4*WIDTH-1:0] mk(input int a);
    logic [WIDTH-1:0] av;
    av = WIDTH'(a);
    return {av, av ^ WIDTH'(21), ~av, av + WIDTH'(1)};
  endfunction

  function automatic logic [1:0] exp_contend(input int i);
`ifdef SCHED_STRICT_PRIO_EN
    return (i >= 0) ? 2'b01 : 2'b00;
`else
    return (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
  endfunction

  // Monitor: every accepted result must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        chk("res_word", 32'({res_tag, res_data}), 32'(mon_exp));
      end
    end
  end

  // One cycle: drive after the edge (releasing reset), check the handshake at negedge.
  task automatic drive(input logic [1:0] v, input int a0, input int a1,
                       input logic [1:0] exp_rdy, input logic rr, input string name);
    logic [4*WIDTH-1:0] exp_ops;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_valid = v;
    ops0      = mk(a0);
    ops1      = mk(a1);
    res_ready = rr;
    @(negedge clk);
    exp_ops = (exp_rdy == 2'b01) ? mk(a0) : (exp_rdy == 2'b10) ? mk(a1) : '0;
    chk({name, "_ready"}, 32'(req_ready), 32'(exp_rdy));
    chk({name, "_issue"}, 32'(pipe_issue), 32'(exp_rdy != 2'b00));
    chk({name, "_ops"}, 32'(pipe_ops), 32'(exp_ops));
    if (exp_rdy == 2'b01) sb.push_back({1'b0, WIDTH'(a0)});
    else if (exp_rdy == 2'b10) sb.push_back({1'b1, WIDTH'(a1)});
  endtask

  // Asserts reset with requests pending; the next drive() releases it.
  task automatic do_reset(input logic drained);
    if (drained) chk("sb_drained", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = 2'b11;
    res_ready = 1'b1;
    ops0      = mk(7);
    ops1      = mk(9);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_issue", 32'(pipe_issue), 32'd0);
    chk("rst_ops", 32'(pipe_ops), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_res_tag", 32'(res_tag), 32'd0);
    sb.delete();
  endtask

  // Counts edges from the transfer edge to the edge that makes the result visible.
  task automatic measure_latency(input string name);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    lat = 0;
    while (!res_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk(name, 32'(lat), 32'(LAT));
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      drive(2'b00, 0, 0, 2'b00, 1'b1, "drain");
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 2'b00;
    ops0      = '0;
    ops1      = '0;
    res_ready = 1'b0;

    // Basic latency; the request rides the first edge after reset release.
    do_reset(1'b1);
    drive(2'b01, 10, 0, 2'b01, 1'b1, "lat");
    measure_latency("lat_basic");
    drain();

    // Contention from reset: round-robin alternates starting with requester 0.
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 20 + i, 40 + i, exp_contend(i), 1'b1, "contend");
    end
    drain();

    // Backpressure: exactly DEPTH transfers, then no credit.
    do_reset(1'b1);
    for (int i = 0; i < DEPTH; i++) drive(2'b01, 50 + i, 0, 2'b01, 1'b0, "bp_fill");
    for (int i = 0; i < 4; i++) drive(2'b01, 54 + i, 0, 2'b00, 1'b0, "bp_hold");
    chk("bp_full_valid", 32'(res_valid), 32'd1);

    // From full: one pop frees one credit, one new transfer, then full again.
    drive(2'b01, 60, 0, 2'b00, 1'b1, "full_pop");
    drive(2'b01, 61, 0, 2'b01, 1'b0, "full_refill");
    for (int i = 0; i < 3; i++) drive(2'b01, 62, 0, 2'b00, 1'b0, "full_hold");
    drain();

    // Mid-operation reset discards in-flight work.
    do_reset(1'b1);
    drive(2'b01, 1, 0, 2'b01, 1'b1, "mid_a");
    drive(2'b01, 2, 0, 2'b01, 1'b1, "mid_b");
    drive(2'b00, 0, 0, 2'b00, 1'b1, "mid_gap");
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(2'b00, 0, 0, 2'b00, 1'b1, "quiet");
      chk("quiet_res_valid", 32'(res_valid), 32'd0);
    end
    drive(2'b01, 30, 0, 2'b01, 1'b1, "post_rst");
    measure_latency("lat_post_rst");
    drain();

    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_scheduler.md
PIPE_SCHEDULER -- requirements
Module: pipe_scheduler

Interface
- REQ-001 SHALL have parameter: WIDTH, 6, operand and result width.
- REQ-002 SHALL have parameter: LAT, 3, datapath latency in cycles (stages).
- REQ-003 SHALL have parameter: DEPTH, 4, result FIFO entries; power of two, DEPTH >= 2.
- REQ-004 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
- REQ-005 SHALL have port: rst_n  input  1  asynchronous active-low reset.
- REQ-006 SHALL have ports: req_valid  input  2, and req_ready  output  2; per-requester handshake.
- REQ-007 SHALL have ports: ops0 and ops1  input  4*WIDTH each; operands {A,B,C,D}, with A in the MSBs.
- REQ-008 SHALL have ports: pipe_ops  output  4*WIDTH, and pipe_issue  output  1; drive the datapath.
- REQ-009 SHALL have port: pipe_out  input  WIDTH  datapath result.
- REQ-010 SHALL have ports: res_valid  output  1, res_ready  input  1, res_data  output  WIDTH, res_tag  output  1 (requester id).

Function
- REQ-011 SHALL treat a transfer on requester i as req_valid[i] && req_ready[i] in the same cycle.
- REQ-012 SHALL assert at most one req_ready bit per cycle.
- REQ-013 SHALL assert req_ready[i] only when req_valid[i]=1, requester i wins arbitration, and credit is available.
- REQ-014 SHALL define credit as available when occupancy < DEPTH.
- REQ-015 SHALL define occupancy as (valid in-flight entries + FIFO count), held in a counter of width clog2(DEPTH)+1.
- REQ-016 SHALL apply the occupancy update once per cycle: +1 on issue, -1 on result pop, unchanged when both occur.
- REQ-017 SHALL drive pipe_issue = 1 in any transfer cycle and pipe_ops = the granted requester's ops (combinational mux).
- REQ-018 SHALL drive pipe_issue = 0 and pipe_ops = 0 in every cycle without a transfer.
- REQ-019 SHALL arbitrate round-robin: on a conflict, the requester not granted last wins.
- REQ-020 SHALL update the last-grant pointer only on a transfer.
- REQ-021 SHALL track in-flight work in an LAT-entry shift register of {valid, tag} that advances every cycle, entering {pipe_issue, granted id}.
- REQ-022 SHALL, when the tail entry is valid, push {pipe_out, tag} into the FIFO at that edge; for an issue in cycle N, this captures pipe_out in cycle N+LAT.
- REQ-023 SHALL present the FIFO head on res_data/res_tag with res_valid = (FIFO not empty).
- REQ-024 SHALL pop the FIFO on res_valid && res_ready.
- REQ-025 SHALL support a simultaneous push and pop in the same cycle, including the full and empty cases.
- REQ-026 SHALL never overflow the FIFO (guaranteed by credit); an internal assertion SHALL flag a push while full.
- REQ-027 SHALL wrap FIFO read and write pointers modulo DEPTH.
- REQ-028 SHALL have no stall path into the datapath; backpressure acts only through withheld req_ready.

Reset
- REQ-029 SHALL, on rst_n low, immediately clear: occupancy, FIFO pointers and count, all in-flight valid bits, and the last-grant pointer (to 1, so requester 0 wins first).
- REQ-030 SHALL hold req_ready=0, pipe_issue=0, pipe_ops=0, res_valid=0, res_data=0 and res_tag=0 while in reset.
- REQ-031 SHALL discard work in flight at a mid-operation reset; datapath results for those issues SHALL never be pushed.
- REQ-032 SHALL allow the first transfer at the first rising edge after rst_n deasserts.

Configuration
- REQ-033 SHALL, with SCHED_STRICT_PRIO_EN defined, give requester 0 fixed priority over requester 1 and remove the last-grant pointer.
- REQ-034 SHALL, without SCHED_STRICT_PRIO_EN defined, use round-robin per REQ-019/REQ-020.

Verification
- REQ-035 SHALL cover basic latency: bench datapath model is pipe_out = A field of pipe_ops delayed 3 cycles; ops0 A=10 issued in cycle 5 -> res_valid=1, res_data=10, res_tag=0 in cycle 8 (res_ready=1).
- REQ-036 SHALL cover contention: both req_valid held high for 4 cycles with res_ready=1 -> grants 0,1,0,1.
- REQ-037 SHALL cover contention under SCHED_STRICT_PRIO_EN: same stimulus as REQ-036 -> grants 0,0,0,0.
- REQ-038 SHALL cover backpressure: res_ready=0, req_valid[0]=1 continuously -> exactly 4 transfers, then req_ready stays 0; FIFO holds 4 results in issue order.
- REQ-039 SHALL cover full plus simultaneous events: from the full state, res_ready=1 for one cycle -> one pop; the next cycle grants one new transfer; occupancy returns to 4 and is never 5.
- REQ-040 SHALL cover mid-operation reset: rst_n pulsed low 1 cycle after 2 issues -> res_valid stays 0 for 5 cycles; the next issue A=30 returns res_data=30 after 3 cycles.
